// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: instruction bus, fetch->decode payload,
// fetch FSM states and reset/step defaults for the program counter.
package fetch_unit_pkg;

  // Common bus/word types.
  typedef logic [63:0] addr_t;
  typedef logic [31:0] u32;

  // Instruction bus request: held until the matching data_ok.
  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  // Instruction bus response: data is meaningful only when data_ok is high.
  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  // Payload handed to decode.
  typedef struct packed {
    logic  valid;
    addr_t pc;
    u32    raw_instr;
  } fetch_data_t;

  // Fetch control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Default PC after reset and sequential increment in bytes.
  localparam addr_t DEF_PC_INIT = 64'h0000_0000_8000_0000;
  localparam addr_t DEF_PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with next-pc selection.
// A redirect target always wins; otherwise the pc advances by PC_STEP when
// the fetched word is kept, and holds in every other cycle.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter addr_t PC_INIT = DEF_PC_INIT,
  parameter addr_t PC_STEP = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [61:0] redirect_tgt_i,
  input  logic        advance_i,
  output addr_t       pc_o,
  output addr_t       pc_next_o
);

  addr_t pc_q;
  addr_t pc_d;

  // Next-pc select: redirect (word aligned) > sequential step > hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_tgt_i, 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP;  // wraps silently at 2^64
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset to PC_INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_INIT;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues at most one instruction bus request at a
// time and delivers fetched words to decode through a one-entry registered
// buffer. Redirects flush the buffer; a request already on the bus is never
// withdrawn, its late response is dropped in FLUSH instead.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t PC_INIT = DEF_PC_INIT,
  parameter addr_t PC_STEP = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  addr_t       redirect_pc,
  output fetch_data_t dataF
);

  // FSM and request registers.
  fetch_state_t state_q, state_d;
  logic         req_valid_q, req_valid_d;
  addr_t        req_addr_q, req_addr_d;

  // Output buffer registers.
  logic         buf_valid_q, buf_valid_d;
  addr_t        buf_pc_q, buf_pc_d;
  u32           buf_instr_q, buf_instr_d;

  // Handshake helpers.
  logic         can_accept;
  logic         consume;
  logic         fill;
  logic         launch;
  addr_t        pc_cur;
  addr_t        pc_next;

  // addr_ok carries no information for a single-outstanding fetcher and the
  // low redirect bits are forced to zero, so both are intentionally sunk.
  logic         unused_bits;
  assign unused_bits = ^{iresp.addr_ok, redirect_pc[1:0]};

  // Buffer can take a new word this cycle if empty or being drained.
  assign can_accept = !buf_valid_q || !stall;
  assign consume    = buf_valid_q && !stall;

  fetch_unit_pc_reg #(
    .PC_INIT (PC_INIT),
    .PC_STEP (PC_STEP)
  ) u_pc_reg (
    .clk            (clk),
    .reset          (reset),
    .redirect_i     (redirect_valid),
    .redirect_tgt_i (redirect_pc[63:2]),
    .advance_i      (fill),
    .pc_o           (pc_cur),
    .pc_next_o      (pc_next)
  );

  // Next-state logic. A response that arrives while the buffer is full and
  // stalled cannot be stored; it is dropped and the same pc is fetched again
  // later, so no instruction is lost or duplicated.
  always_comb begin
    state_d = state_q;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          state_d = IDLE;
        end else if (can_accept) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (iresp.data_ok) begin
          if (redirect_valid) begin
            state_d = IDLE;
          end else begin
            fill    = can_accept;
            state_d = can_accept ? REQ : IDLE;
          end
        end else if (redirect_valid) begin
          state_d = FLUSH;
        end else begin
          state_d = REQ;
        end
      end
      FLUSH: begin
        if (iresp.data_ok) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request channel: a new request is launched whenever REQ is entered fresh
  // or re-entered after a response; otherwise valid/addr stay frozen, which
  // also keeps the stale address on the bus through FLUSH.
  always_comb begin
    launch      = (state_d == REQ) && ((state_q != REQ) || iresp.data_ok);
    req_valid_d = (state_d == REQ) || (state_d == FLUSH);
    if (launch) begin
      req_addr_d = pc_next;
    end else begin
      req_addr_d = req_addr_q;
    end
  end

  // Output buffer: redirect empties it, a stored response refills it (even
  // in the same cycle as a consume), a consume alone empties it.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (redirect_valid) begin
      buf_valid_d = 1'b0;
    end else if (fill) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = pc_cur;
      buf_instr_d = iresp.data;
    end else if (consume) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // State, request and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= 64'd0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 64'd0;
      buf_instr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // Outputs come straight from registers.
  assign ireq.valid      = req_valid_q;
  assign ireq.addr       = req_addr_q;
  assign dataF.valid     = buf_valid_q;
  assign dataF.pc        = buf_pc_q;
  assign dataF.raw_instr = buf_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bus responder with programmable
// latency, a scoreboard of expected {pc, instr} in program order, and
// directed scenarios for reset, latency, stall, redirect and late responses.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stall;
  logic        redirect_valid;
  addr_t       redirect_pc;
  fetch_data_t dataF;

  int          n_checks;
  int          n_errors;

  addr_t       sb_q[$];
  addr_t       req_log[$];
  logic        in_flight;
  addr_t       inflight_addr;
  logic        chk_req;
  addr_t       exp_req;
  logic        post_redir;
  logic        prev_hold;
  fetch_data_t prev_data;
  int          n_pops;
  int          bus_lat;
  int          wait_cnt;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF          (dataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic u32 bus_data(input addr_t a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_seq(input addr_t start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 64'(4 * i));
  endtask

  // Observes the current cycle (inputs already driven, before the next posedge).
  task automatic monitor();
    addr_t e;
    if (reset) begin
      in_flight  = 1'b0;
      post_redir = 1'b0;
      prev_hold  = 1'b0;
      return;
    end
    if (post_redir) chk("redirect_clears_buf", 64'(dataF.valid), 64'd0);
    post_redir = 1'b0;
    if (prev_hold) begin
      chk("hold_valid", 64'(dataF.valid), 64'(prev_data.valid));
      chk("hold_pc", dataF.pc, prev_data.pc);
      chk("hold_instr", 64'(dataF.raw_instr), 64'(prev_data.raw_instr));
    end
    if (in_flight) begin
      chk("req_hold_valid", 64'(ireq.valid), 64'd1);
      chk("req_hold_addr", ireq.addr, inflight_addr);
    end
    if (!redirect_valid && dataF.valid && !stall) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_pc", dataF.pc, e);
        chk("sb_instr", 64'(dataF.raw_instr), 64'(bus_data(e)));
        n_pops++;
      end else begin
        chk("unexpected_instr", 64'(dataF.valid), 64'd0);
      end
    end
    if (ireq.valid) begin
      if (!in_flight) begin
        req_log.push_back(ireq.addr);
        if (chk_req) begin
          chk("req_addr", ireq.addr, exp_req);
          chk_req = 1'b0;
        end
      end
      in_flight     = !iresp.data_ok;
      inflight_addr = ireq.addr;
    end else begin
      in_flight = 1'b0;
    end
    if (redirect_valid) begin
      post_redir = 1'b1;
      chk_req    = 1'b1;
      exp_req    = {redirect_pc[63:2], 2'b00};
    end
    prev_hold = !redirect_valid && stall && dataF.valid;
    prev_data = dataF;
  endtask

  // One cycle: check the current cycle, advance, then the bus answers.
  task automatic tick();
    monitor();
    @(negedge clk);
    iresp.addr_ok = ireq.valid;
    if (reset) begin
      iresp.data_ok = 1'b0;
      iresp.data    = 32'h0BAD_F00D;
      wait_cnt      = 0;
    end else if (ireq.valid) begin
      if (wait_cnt >= bus_lat) begin
        iresp.data_ok = 1'b1;
        iresp.data    = bus_data(ireq.addr);
        wait_cnt      = 0;
      end else begin
        iresp.data_ok = 1'b0;
        iresp.data    = 32'h0BAD_F00D;
        wait_cnt++;
      end
    end else begin
      iresp.data_ok = 1'b0;
      iresp.data    = 32'h0BAD_F00D;
      wait_cnt      = 0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    tick();
    chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst_ireq_addr", ireq.addr, 64'd0);
    chk("rst_dataF_valid", 64'(dataF.valid), 64'd0);
    chk("rst_dataF_pc", dataF.pc, 64'd0);
    chk("rst_dataF_instr", 64'(dataF.raw_instr), 64'd0);
    tick();
    reset   = 1'b0;
    sb_q.delete();
    req_log.delete();
    chk_req = 1'b1;
    exp_req = DEF_PC_INIT;
  endtask

  task automatic drain(input int bound);
    stall = 1'b0;
    for (int i = 0; i < bound && sb_q.size() > 0; i++) tick();
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    stall = 1'b1;
  endtask

  task automatic wait_req_valid();
    for (int i = 0; i < 10 && !ireq.valid; i++) tick();
    chk("req_seen", 64'(ireq.valid), 64'd1);
  endtask

  task automatic do_redirect(input addr_t target, input int n);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    sb_q.delete();
    push_seq({target[63:2], 2'b00}, n);
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int n0;
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    iresp          = '0;
    bus_lat        = 0;
    wait_cnt       = 0;
    in_flight      = 1'b0;
    chk_req        = 1'b0;
    exp_req        = 64'd0;
    post_redir     = 1'b0;
    prev_hold      = 1'b0;
    prev_data      = '0;
    n_pops         = 0;

    // 1: zero-latency bus, no stall -> one instruction per cycle.
    bus_lat = 0;
    do_reset();
    push_seq(DEF_PC_INIT, 20);
    for (int i = 0; i < 10 && !dataF.valid; i++) tick();
    chk("t1_first_valid", 64'(dataF.valid), 64'd1);
    n0 = n_pops;
    for (int i = 0; i < 10; i++) tick();
    chk("t1_throughput", 64'(n_pops - n0), 64'd10);
    chk("t1_req0", req_log[0], 64'h0000_0000_8000_0000);
    chk("t1_req1", req_log[1], 64'h0000_0000_8000_0004);
    chk("t1_req2", req_log[2], 64'h0000_0000_8000_0008);
    drain(50);

    // 2: data_ok after three wait cycles.
    bus_lat = 3;
    do_reset();
    push_seq(DEF_PC_INIT, 3);
    cnt = 0;
    for (int i = 0; i < 20 && !iresp.data_ok; i++) begin
      tick();
      if (ireq.valid && !iresp.data_ok) cnt++;
    end
    chk("t2_data_ok_seen", 64'(iresp.data_ok), 64'd1);
    chk("t2_wait_cycles", 64'(cnt), 64'd3);
    chk("t2_valid_before", 64'(dataF.valid), 64'd0);
    tick();
    chk("t2_valid_after", 64'(dataF.valid), 64'd1);
    chk("t2_pc_after", dataF.pc, DEF_PC_INIT);
    drain(100);

    // 3: four stalled cycles with the buffer full.
    bus_lat = 0;
    do_reset();
    push_seq(DEF_PC_INIT, 16);
    for (int i = 0; i < 10 && !dataF.valid; i++) tick();
    stall = 1'b1;
    n0 = req_log.size();
    for (int i = 0; i < 4; i++) tick();
    chk("t3_extra_reqs_le1", 64'((req_log.size() - n0) <= 1), 64'd1);
    drain(100);

    // 4: redirect while the request waits -> FLUSH, stale data dropped.
    bus_lat = 6;
    do_reset();
    wait_req_valid();
    do_redirect(64'h0000_0000_8000_0103, 3);
    chk("t4_flush_req_valid", 64'(ireq.valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_flush_dataF_valid", 64'(dataF.valid), 64'd0);
    end
    drain(200);

    // 4b: second redirect while flushing -> newest target wins.
    do_reset();
    wait_req_valid();
    do_redirect(64'h0000_0000_8000_0103, 2);
    tick();
    do_redirect(64'h0000_0000_8000_0207, 3);
    drain(200);

    // 5: redirect in the same cycle as data_ok.
    bus_lat = 2;
    do_reset();
    for (int i = 0; i < 10 && !iresp.data_ok; i++) tick();
    chk("t5_data_ok_seen", 64'(iresp.data_ok), 64'd1);
    do_redirect(64'h0000_0000_8000_0202, 3);
    drain(100);

    // 6: reset in REQ, then a late data_ok while IDLE.
    bus_lat = 4;
    do_reset();
    wait_req_valid();
    do_reset();
    iresp.data_ok = 1'b1;
    iresp.data    = 32'hDEAD_BEEF;
    push_seq(DEF_PC_INIT, 3);
    tick();
    chk("t6_late_ok_ignored", 64'(dataF.valid), 64'd0);
    drain(100);

    // 7: pc wrap at 2^64 after a redirect near the top.
    bus_lat = 0;
    do_reset();
    wait_req_valid();
    do_redirect(64'hFFFF_FFFF_FFFF_FFF9, 4);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
